pulse_burst_gen: RTL and testbench
==================================

// Module: pulse_burst_gen
// PURPOSE
//  Expands one trigger event into a burst of burst_len single-cycle pulses, GAP idle cycles apart.
//  Inverse of the pulse-dividing counters in the timing chain: one pulse in, N pulses out.
//  Drives tick-consuming logic (display blink, step timers) from a single game event.
//  Raises a done pulse once the burst completes.
// PARAMETERS
//  CNT_W  5  width of burst_len and the remaining-pulse counter (max burst 2^CNT_W-1)
//  GAP    3  low cycles between consecutive output pulses; legal range 1..255
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset, synchronous, active-high
//  trig_in    in   1      trigger; only a rising edge (0->1 between samples) starts a burst
//  burst_len  in   CNT_W  pulse count, latched on the accepted trigger edge
//  pulse_out  out  1      one-cycle-high burst pulses
//  busy       out  1      high from the first pulse through the last pulse
//  done       out  1      one-cycle-high strobe the cycle after the last pulse
// BEHAVIOUR
//  - Outputs are Moore-decoded from registered state; no combinational path from inputs.
//  - Reset: state=IDLE, trig_q=0, rem=0, gap_cnt=0; pulse_out=0, busy=0, done=0.
//  - Edge detect: rise = trig_in & ~trig_q; trig_q <= trig_in every cycle, including when busy.
//  - FSM states:
//    - IDLE: all outputs 0.
//      - rise with burst_len!=0: rem<=burst_len, go to PULSE.
//      - rise with burst_len==0: go to DONE.
//    - PULSE: pulse_out=1, busy=1.
//      - rem==1: go to DONE.
//      - otherwise: rem<=rem-1, gap_cnt<=GAP-1, go to GAP.
//    - GAP: pulse_out=0, busy=1.
//      - gap_cnt==0: go to PULSE.
//      - otherwise: gap_cnt<=gap_cnt-1.
//    - DONE: done=1, busy=0.
//      - Behaves as IDLE for rise: same transitions, so back-to-back bursts are legal.
//      - Otherwise go to IDLE.
//  - Latency: rise sampled at edge k -> pulse_out high in cycle k+1.
//  - Burst spans N+(N-1)*GAP cycles; done is high exactly one cycle after the last pulse.
//  - rise in PULSE/GAP is ignored unless the option below is enabled; no queueing.
//  - A trigger held high fires exactly once; it must drop low before it can fire again.
//  - Trigger held high through rst fires once on the first cycle after rst deasserts (trig_q resets to 0).
//  - rst mid-burst: next edge forces IDLE, so no further pulses and no done strobe.
//  - Counter arithmetic is unsigned, CNT_W bits.
//    - rem never decrements below 1, so it cannot wrap.
//    - gap_cnt is 8 bits wide.
// CONFIGURATION
//  PULSE_BURST_RETRIG_EN defined:
//    - rise in PULSE or GAP aborts the current burst.
//    - burst_len is relatched; next cycle is PULSE; no done for the aborted burst.
//    - burst_len==0 on retrigger: go to DONE.
//  PULSE_BURST_RETRIG_EN undefined: rise while busy is ignored (default build).
// TESTING  (GAP=3, CNT_W=5, cycle = edge index after rst release)
//  1 burst_len=3, 1-cycle trig at 10 -> pulse_out high at 11,15,19; busy 11..19; done at 20 only.
//  2 burst_len=0, trig at 10 -> no pulse_out, busy stays 0, done at 11.
//  3 burst_len=2, trig held high 10..60 -> exactly 2 pulses (11,15), done at 16, nothing after.
//  4 burst_len=3, trig at 10, rst at 13 -> pulse at 11 only, no done; trig at 20 -> pulses 21,25,29.
//  5 burst_len=3 trig at 10, then burst_len=2 trig at 16:
//    - RETRIG_EN: pulses 11,15,17,21; done at 22.
//    - otherwise: pulses 11,15,19; done at 20.
//  6 burst_len=1 -> single pulse at 11, done at 12; burst_len=31 -> 31 pulses, last at 11+30*4=131, done at 132.

Source files
------------

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: turns one trigger rising edge into burst_len pulses, GAP idle cycles apart, then strobes done.
// Define PULSE_BURST_RETRIG_EN to let a new edge abort and restart a running burst.
module pulse_burst_gen #(
  parameter int CNT_W = 5,
  parameter int GAP   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] burst_len,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);
  localparam logic [7:0] GAP_RELOAD = 8'(GAP - 1);
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;
  state_t           r_state, w_state;
  logic             r_trig_q, w_rise, w_start, w_last;
  logic [CNT_W-1:0] r_rem, w_rem;
  logic [7:0]       r_gap_cnt, w_gap_cnt;
  logic             r_pulse, r_busy, r_done;
  assign w_rise = trig_in & ~r_trig_q;
  assign w_last = (r_rem == CNT_W'(1));
`ifdef PULSE_BURST_RETRIG_EN
  assign w_start = w_rise;
`else
  assign w_start = w_rise & ((r_state == S_IDLE) | (r_state == S_DONE));
`endif
  always_comb begin
    w_state   = r_state;
    w_rem     = r_rem;
    w_gap_cnt = r_gap_cnt;
    if (w_start) begin
      w_state = (burst_len == '0) ? S_DONE : S_PULSE;
      w_rem   = (burst_len == '0) ? r_rem : burst_len;
    end else begin
      case (r_state)
        S_PULSE: begin
          w_state   = w_last ? S_DONE : S_GAP;
          w_rem     = w_last ? r_rem : r_rem - CNT_W'(1);
          w_gap_cnt = w_last ? r_gap_cnt : GAP_RELOAD;
        end
        S_GAP: begin
          w_state   = (r_gap_cnt == 8'd0) ? S_PULSE : S_GAP;
          w_gap_cnt = (r_gap_cnt == 8'd0) ? r_gap_cnt : r_gap_cnt - 8'd1;
        end
        S_DONE:  w_state = S_IDLE;
        default: w_state = r_state;
      endcase
    end
  end
  // outputs are registered from the next state so they line up exactly with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_trig_q  <= 1'b0;
      r_rem     <= '0;
      r_gap_cnt <= '0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_trig_q  <= trig_in;
      r_rem     <= w_rem;
      r_gap_cnt <= w_gap_cnt;
      r_pulse   <= (w_state == S_PULSE);
      r_busy    <= (w_state == S_PULSE) | (w_state == S_GAP);
      r_done    <= (w_state == S_DONE);
    end
  end
  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb_pulse_burst_gen: self-checking bench for pulse_burst_gen against a timeline model of each burst.
module tb_pulse_burst_gen;
  localparam int CNT_W = 5;
  localparam int GAP   = 3;
  localparam int P     = GAP + 1;
`ifdef PULSE_BURST_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             trig_in = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             pulse_out, busy, done;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit m_act = 1'b0;
  bit m_prev = 1'b0;
  int m_t = 0;
  int m_n = 0;
  int agg_p, agg_b;
  int pq[$];
  int dq[$];
  typedef struct {
    int len;
    int hold;
    int np;
    int nb;
    int done_off;
  } vec_t;
  vec_t tbl[5];

  pulse_burst_gen #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .burst_len(burst_len),
    .pulse_out(pulse_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // A burst accepted at edge m_t occupies spec cycles m_t+1 .. m_t+1+(n-1)*P, pulses every P cycles.
  function automatic bit m_busy(input int s);
    int d = s - m_t;
    return m_act && (m_n > 0) && (d >= 1) && (d <= 1 + (m_n - 1) * P);
  endfunction
  function automatic bit m_pulse(input int s);
    return m_busy(s) && (((s - m_t - 1) % P) == 0);
  endfunction
  function automatic bit m_done(input int s);
    return m_act && ((s - m_t) == ((m_n == 0) ? 1 : 2 + (m_n - 1) * P));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input int got[$], input int want[$], input int base);
    chk({nm, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) chk(nm, got[i] - base, want[i]);
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then check the outputs seen after it.
  task automatic step(input logic r, input logic t, input logic [CNT_W-1:0] l);
    bit acc;
    rst = r;
    trig_in = t;
    burst_len = l;
    acc = !r && t && !m_prev && (!m_busy(cyc + 1) || RETRIG);
    @(posedge clk);
    cyc++;
    if (r) begin
      m_act = 1'b0;
      m_prev = 1'b0;
    end else begin
      if (acc) begin
        m_act = 1'b1;
        m_t = cyc;
        m_n = int'(l);
      end
      m_prev = t;
    end
    #1;
    chk("pulse_out", pulse_out, m_pulse(cyc + 1));
    chk("busy", busy, m_busy(cyc + 1));
    chk("done", done, m_done(cyc + 1));
    if (pulse_out === 1'b1) begin agg_p++; pq.push_back(cyc + 1); end
    if (busy === 1'b1) agg_b++;
    if (done === 1'b1) dq.push_back(cyc + 1);
  endtask

  task automatic clear_agg();
    agg_p = 0;
    agg_b = 0;
    pq.delete();
    dq.delete();
  endtask

  initial begin
    int base;
    int e[$];
    tbl[0] = '{3, 1, 3, 9, 10};
    tbl[1] = '{0, 1, 0, 0, 1};
    tbl[2] = '{2, 51, 2, 5, 6};
    tbl[3] = '{1, 1, 1, 1, 2};
    tbl[4] = '{31, 1, 31, 121, 122};
    clear_agg();
    // trigger held high through reset fires once right after release
    repeat (3) step(1'b1, 1'b1, CNT_W'(2));
    clear_agg();
    step(1'b0, 1'b1, CNT_W'(2));
    base = cyc;
    repeat (15) step(1'b0, 1'b1, CNT_W'(2));
    e = '{1, 5};
    chk_q("held_rst_pulse", pq, e, base);
    e = '{6};
    chk_q("held_rst_done", dq, e, base);
    for (int i = 0; i < 5; i++) begin
      repeat (4) step(1'b0, 1'b0, '0);
      clear_agg();
      step(1'b0, 1'b1, CNT_W'(tbl[i].len));
      base = cyc;
      for (int j = 1; j < tbl[i].hold; j++) step(1'b0, 1'b1, CNT_W'(tbl[i].len));
      while (cyc - base < 140) step(1'b0, 1'b0, '0);
      chk("tbl_pulses", agg_p, tbl[i].np);
      chk("tbl_busy_cycles", agg_b, tbl[i].nb);
      chk("tbl_done_count", dq.size(), 1);
      chk("tbl_done_offset", (dq.size() > 0) ? dq[0] - base : -1, tbl[i].done_off);
    end
    // reset in the middle of a burst kills it without a done strobe
    repeat (4) step(1'b0, 1'b0, '0);
    clear_agg();
    step(1'b0, 1'b1, CNT_W'(3));
    base = cyc;
    repeat (2) step(1'b0, 1'b0, CNT_W'(3));
    step(1'b1, 1'b0, CNT_W'(3));
    repeat (6) step(1'b0, 1'b0, CNT_W'(3));
    step(1'b0, 1'b1, CNT_W'(3));
    repeat (15) step(1'b0, 1'b0, CNT_W'(3));
    e = '{1, 11, 15, 19};
    chk_q("rst_mid_pulse", pq, e, base);
    e = '{20};
    chk_q("rst_mid_done", dq, e, base);
    // second edge arriving during the gap
    repeat (4) step(1'b0, 1'b0, '0);
    clear_agg();
    step(1'b0, 1'b1, CNT_W'(3));
    base = cyc;
    repeat (5) step(1'b0, 1'b0, CNT_W'(3));
    step(1'b0, 1'b1, CNT_W'(2));
    repeat (16) step(1'b0, 1'b0, CNT_W'(2));
    e = RETRIG ? '{1, 5, 7, 11} : '{1, 5, 9};
    chk_q("retrig_pulse", pq, e, base);
    e = RETRIG ? '{12} : '{10};
    chk_q("retrig_done", dq, e, base);
    repeat (3000)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
           ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 4)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
